// File: rtl/b_response_router_if.sv
// Write-response bus between the B-channel arbiter/slaves, the router and masters 0..2.
// The slave modport is the router's view; the master modport is the surrounding fabric's view.
interface b_response_router_if #(
   parameter int unsigned sID_width  = 6,
   parameter int unsigned RESP_width = 2
);
   logic                    ID_valid;
   logic [sID_width-1:0]    ID;
   logic [2:0]              B_SLV_sel;
   logic                    BVALID0, BVALID1, BVALID2, BVALID3, BVALID4;
   logic [RESP_width-1:0]   BRESP0, BRESP1, BRESP2, BRESP3, BRESP4;
   logic                    BREADY0, BREADY1, BREADY2, BREADY3, BREADY4;
   logic                    M0_BVALID, M1_BVALID, M2_BVALID;
   logic [sID_width-3:0]    M0_BID, M1_BID, M2_BID;
   logic [RESP_width-1:0]   M0_BRESP, M1_BRESP, M2_BRESP;
   logic                    M0_BREADY, M1_BREADY, M2_BREADY;
   logic                    count_update;
   logic                    decerr_drop;

   modport slave (
      input  ID_valid, ID, B_SLV_sel,
      input  BVALID0, BVALID1, BVALID2, BVALID3, BVALID4,
      input  BRESP0, BRESP1, BRESP2, BRESP3, BRESP4,
      output BREADY0, BREADY1, BREADY2, BREADY3, BREADY4,
      output M0_BVALID, M1_BVALID, M2_BVALID,
      output M0_BID, M1_BID, M2_BID,
      output M0_BRESP, M1_BRESP, M2_BRESP,
      input  M0_BREADY, M1_BREADY, M2_BREADY,
      output count_update, decerr_drop
   );

   modport master (
      output ID_valid, ID, B_SLV_sel,
      output BVALID0, BVALID1, BVALID2, BVALID3, BVALID4,
      output BRESP0, BRESP1, BRESP2, BRESP3, BRESP4,
      input  BREADY0, BREADY1, BREADY2, BREADY3, BREADY4,
      input  M0_BVALID, M1_BVALID, M2_BVALID,
      input  M0_BID, M1_BID, M2_BID,
      input  M0_BRESP, M1_BRESP, M2_BRESP,
      output M0_BREADY, M1_BREADY, M2_BREADY,
      input  count_update, decerr_drop
   );
endinterface

// File: rtl/b_response_router.sv
// B-channel response router: accepts the granted slave response into a one-entry buffer and
// delivers it to the master named by ID[top:top-1]. Optional HOLD timeout: B_RESP_TIMEOUT_EN.
module b_response_router #(
   parameter int unsigned sID_width  = 6,
   parameter int unsigned RESP_width = 2
) (
   input logic              clk,
   input logic              reset,
   b_response_router_if.slave bus
);

   localparam int unsigned MidW = sID_width - 2;

   typedef enum logic [1:0] {StIdle, StHold, StRetire} state_e;

   state_e                state_q, state_d;
   logic [sID_width-1:0]  hold_id_q, hold_id_d;
   logic [RESP_width-1:0] hold_resp_q, hold_resp_d;
   logic                  count_update_q, count_update_d;
   logic                  decerr_drop_q, decerr_drop_d;
`ifdef B_RESP_TIMEOUT_EN
   logic [9:0]            tmo_cnt_q, tmo_cnt_d;
`endif

   logic [4:0]            bvalid;
   logic [4:0]            bready;
   logic [RESP_width-1:0] bresp [5];
   logic [RESP_width-1:0] sel_resp;
   logic [1:0]            hold_mst;
   logic [2:0]            mvalid;
   logic [2:0]            mready;
   logic                  accept;
   logic                  handshake;

   assign bvalid   = {bus.BVALID4, bus.BVALID3, bus.BVALID2, bus.BVALID1, bus.BVALID0};
   assign bresp[0] = bus.BRESP0;
   assign bresp[1] = bus.BRESP1;
   assign bresp[2] = bus.BRESP2;
   assign bresp[3] = bus.BRESP3;
   assign bresp[4] = bus.BRESP4;
   assign mready   = {bus.M2_BREADY, bus.M1_BREADY, bus.M0_BREADY};
   assign hold_mst = hold_id_q[sID_width-1 -: 2];

   // Only the granted slave can see ready, and only while the buffer is empty.
   always_comb begin
      bready   = '0;
      sel_resp = '0;
      if (state_q == StIdle && bus.ID_valid) begin
         unique case (bus.B_SLV_sel)
            3'd0: begin bready[0] = bvalid[0]; sel_resp = bresp[0]; end
            3'd1: begin bready[1] = bvalid[1]; sel_resp = bresp[1]; end
            3'd2: begin bready[2] = bvalid[2]; sel_resp = bresp[2]; end
            3'd3: begin bready[3] = bvalid[3]; sel_resp = bresp[3]; end
            3'd4: begin bready[4] = bvalid[4]; sel_resp = bresp[4]; end
            default: ;
         endcase
      end
   end

   assign accept = |bready;

   always_comb begin
      mvalid = '0;
      for (int unsigned k = 0; k < 3; k++) begin
         mvalid[k] = (state_q == StHold) && (hold_mst == 2'(k));
      end
   end

   assign handshake = |(mvalid & mready);

   always_comb begin
      state_d        = state_q;
      hold_id_d      = hold_id_q;
      hold_resp_d    = hold_resp_q;
      count_update_d = 1'b0;
      decerr_drop_d  = 1'b0;
`ifdef B_RESP_TIMEOUT_EN
      tmo_cnt_d      = tmo_cnt_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d     = StHold;
               hold_id_d   = bus.ID;
               hold_resp_d = sel_resp;
`ifdef B_RESP_TIMEOUT_EN
               tmo_cnt_d   = '0;
`endif
            end
         end
         StHold: begin
            if (hold_mst == 2'd3) begin
               // No master 3 exists: drop the response but still retire the arbiter slot.
               state_d        = StRetire;
               count_update_d = 1'b1;
               decerr_drop_d  = 1'b1;
            end else if (handshake) begin
               state_d        = StRetire;
               count_update_d = 1'b1;
`ifdef B_RESP_TIMEOUT_EN
            end else if (tmo_cnt_q == 10'd1023) begin
               state_d        = StRetire;
               count_update_d = 1'b1;
               decerr_drop_d  = 1'b1;
            end else begin
               tmo_cnt_d      = tmo_cnt_q + 10'd1;
`endif
            end
         end
         StRetire: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= StIdle;
         hold_id_q      <= '0;
         hold_resp_q    <= '0;
         count_update_q <= 1'b0;
         decerr_drop_q  <= 1'b0;
`ifdef B_RESP_TIMEOUT_EN
         tmo_cnt_q      <= '0;
`endif
      end else begin
         state_q        <= state_d;
         hold_id_q      <= hold_id_d;
         hold_resp_q    <= hold_resp_d;
         count_update_q <= count_update_d;
         decerr_drop_q  <= decerr_drop_d;
`ifdef B_RESP_TIMEOUT_EN
         tmo_cnt_q      <= tmo_cnt_d;
`endif
      end
   end

   assign bus.BREADY0      = bready[0];
   assign bus.BREADY1      = bready[1];
   assign bus.BREADY2      = bready[2];
   assign bus.BREADY3      = bready[3];
   assign bus.BREADY4      = bready[4];

   assign bus.M0_BVALID    = mvalid[0];
   assign bus.M1_BVALID    = mvalid[1];
   assign bus.M2_BVALID    = mvalid[2];
   // Unselected masters see all-zero ID/response rather than the buffered values.
   assign bus.M0_BID       = mvalid[0] ? hold_id_q[MidW-1:0] : '0;
   assign bus.M1_BID       = mvalid[1] ? hold_id_q[MidW-1:0] : '0;
   assign bus.M2_BID       = mvalid[2] ? hold_id_q[MidW-1:0] : '0;
   assign bus.M0_BRESP     = mvalid[0] ? hold_resp_q : '0;
   assign bus.M1_BRESP     = mvalid[1] ? hold_resp_q : '0;
   assign bus.M2_BRESP     = mvalid[2] ? hold_resp_q : '0;

   assign bus.count_update = count_update_q;
   assign bus.decerr_drop  = decerr_drop_q;

endmodule

// File: tb/tb_b_response_router.sv
// Randomized scoreboard bench for b_response_router; expected deliveries are queued by the driver
// and retired by an independent monitor. Define B_RESP_TIMEOUT_EN to also exercise the timeout.
module tb_b_response_router;

   localparam int unsigned IdW      = 6;
   localparam int unsigned RW       = 2;
   localparam int          TimeoutD = 1 << 20;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   b_response_router_if #(.sID_width(IdW), .RESP_width(RW)) bus ();

   b_response_router #(.sID_width(IdW), .RESP_width(RW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [4:0]    bvalid;
   logic [RW-1:0] bresp [5];
   logic [2:0]    mready;

   assign bus.BVALID0   = bvalid[0];
   assign bus.BVALID1   = bvalid[1];
   assign bus.BVALID2   = bvalid[2];
   assign bus.BVALID3   = bvalid[3];
   assign bus.BVALID4   = bvalid[4];
   assign bus.BRESP0    = bresp[0];
   assign bus.BRESP1    = bresp[1];
   assign bus.BRESP2    = bresp[2];
   assign bus.BRESP3    = bresp[3];
   assign bus.BRESP4    = bresp[4];
   assign bus.M0_BREADY = mready[0];
   assign bus.M1_BREADY = mready[1];
   assign bus.M2_BREADY = mready[2];

   wire [4:0]     bready = {bus.BREADY4, bus.BREADY3, bus.BREADY2, bus.BREADY1, bus.BREADY0};
   wire [2:0]     mvalid = {bus.M2_BVALID, bus.M1_BVALID, bus.M0_BVALID};
   wire [IdW-3:0] mbid  [3];
   wire [RW-1:0]  mresp [3];
   assign mbid[0]  = bus.M0_BID;
   assign mbid[1]  = bus.M1_BID;
   assign mbid[2]  = bus.M2_BID;
   assign mresp[0] = bus.M0_BRESP;
   assign mresp[1] = bus.M1_BRESP;
   assign mresp[2] = bus.M2_BRESP;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [1:0]     mst;
      logic [IdW-3:0] bid;
      logic [RW-1:0]  resp;
      logic           drop;
   } exp_t;

   exp_t sbq[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: retire scoreboard entries on master handshakes and drops; check stability/one-hot.
   logic [2:0]    stall_q = '0;
   logic [IdW-3:0] pbid  [3];
   logic [RW-1:0]  presp [3];
   exp_t           me;

   always @(negedge clk) begin
      if (reset !== 1'b1) begin
         check("bready_onehot", 32'($countones(bready) <= 1), 1);
         check("mvalid_onehot", 32'($countones(mvalid) <= 1), 1);
         for (int k = 0; k < 3; k++) begin
            if (stall_q[k]) begin
               check("stall_valid", mvalid[k], 1);
               check("stall_bid", mbid[k], pbid[k]);
               check("stall_resp", mresp[k], presp[k]);
            end
            if (mvalid[k] && mready[k]) begin
               if (sbq.size() == 0) begin
                  check("unexpected_delivery", 1, 0);
               end else begin
                  me = sbq.pop_front();
                  check("deliver_master", k, me.mst);
                  check("deliver_bid", mbid[k], me.bid);
                  check("deliver_resp", mresp[k], me.resp);
                  check("deliver_not_drop", 0, me.drop);
               end
            end
         end
         if (bus.decerr_drop) begin
            if (sbq.size() == 0) begin
               check("unexpected_drop", 1, 0);
            end else begin
               me = sbq.pop_front();
               check("drop_expected", 1, me.drop);
               check("drop_count_update", bus.count_update, 1);
            end
         end
      end
      for (int k = 0; k < 3; k++) begin
         stall_q[k] = (reset !== 1'b1) && mvalid[k] && !mready[k];
         pbid[k]    = mbid[k];
         presp[k]   = mresp[k];
      end
   end

   task automatic check_outputs_zero(input string tag);
      check({tag, "_bready"}, bready, 0);
      check({tag, "_mvalid"}, mvalid, 0);
      for (int k = 0; k < 3; k++) begin
         check({tag, "_mbid"}, mbid[k], 0);
         check({tag, "_mresp"}, mresp[k], 0);
      end
      check({tag, "_count_update"}, bus.count_update, 0);
      check({tag, "_decerr_drop"}, bus.decerr_drop, 0);
   endtask

   // One grant; d = number of HOLD cycles the target master keeps BREADY low.
   task automatic txn(input int sel, input logic bv, input logic [IdW-1:0] id,
                      input logic [RW-1:0] resp, input int d);
      logic       acc;
      logic       seen;
      logic [1:0] mst;
      int         lat;
      exp_t       e;
      @(posedge clk); #1;
      bus.ID_valid  = 1'b1;
      bus.B_SLV_sel = sel[2:0];
      bus.ID        = id;
      for (int i = 0; i < 5; i++) begin
         bvalid[i] = 1'($urandom);
         bresp[i]  = RW'($urandom);
      end
      if (sel < 5) begin
         bvalid[sel] = bv;
         bresp[sel]  = resp;
      end
      mready = 3'($urandom);
      mst    = id[IdW-1 -: 2];
      acc    = (sel < 5) && bv;
      @(negedge clk);
      check("grant_bready", bready, acc ? (32'd1 << sel) : 32'd0);
      if (!acc) begin
         repeat (3) begin
            @(negedge clk);
            check("idle_bready", bready, 0);
            check("idle_count_update", bus.count_update, 0);
            check("idle_mvalid", mvalid, 0);
         end
         return;
      end
      e.mst  = mst;
      e.bid  = id[IdW-3:0];
      e.resp = resp;
      e.drop = (mst == 2'd3) || (d >= TimeoutD);
      sbq.push_back(e);
      lat  = (mst == 2'd3) ? 2 : ((d >= TimeoutD) ? 1025 : 2 + d);
      seen = 1'b0;
      for (int k = 1; k <= lat + 2 && !seen; k++) begin
         @(posedge clk); #1;
         // Grant churn while busy must be ignored.
         bus.ID_valid  = 1'($urandom);
         bus.B_SLV_sel = 3'($urandom);
         bvalid        = 5'($urandom);
         mready        = 3'($urandom);
         if (mst != 2'd3) mready[mst] = (k > d);
         @(negedge clk);
         check("busy_bready", bready, 0);
         if (bus.count_update) begin
            seen = 1'b1;
            check("retire_latency", k, lat);
         end
      end
      if (!seen) check("retire_timeout", 0, 1);
   endtask

   task automatic quiesce();
      @(posedge clk); #1;
      bus.ID_valid = 1'b0;
      bvalid       = '0;
      mready       = '0;
   endtask

   initial begin
      reset         = 1'b1;
      bus.ID_valid  = 1'b0;
      bus.B_SLV_sel = 3'd7;
      bus.ID        = '0;
      bvalid        = '0;
      mready        = '0;
      for (int i = 0; i < 5; i++) bresp[i] = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_outputs_zero("reset");
      @(posedge clk); #1;
      reset = 1'b0;

      txn(2, 1'b1, 6'b01_0101, 2'b00, 0);          // basic route
      txn(2, 1'b1, 6'b01_0101, 2'b10, 5);          // master backpressure
      txn(0, 1'b1, 6'b11_0011, 2'b01, 0);          // decode error drop
      txn(5, 1'b1, 6'b00_0001, 2'b00, 0);          // no slave selected
      txn(3, 1'b0, 6'b00_0010, 2'b00, 0);          // stale grant
      txn(0, 1'b1, 6'b00_1010, 2'b01, 0);          // back-to-back pair
      txn(4, 1'b1, 6'b10_0110, 2'b11, 0);
      txn(1, 1'b1, 6'b00_0001, 2'b01, 30);         // long wait, no timeout
      repeat (150) begin
         txn($urandom_range(0, 7), 1'($urandom_range(0, 3) != 0), IdW'($urandom),
             RW'($urandom), $urandom_range(0, 6));
      end
`ifdef B_RESP_TIMEOUT_EN
      txn(3, 1'b1, 6'b10_1111, 2'b11, TimeoutD);   // master never ready
`endif
      quiesce();

      // Reset while master 0 holds a pending response.
      @(posedge clk); #1;
      bus.ID_valid  = 1'b1;
      bus.B_SLV_sel = 3'd0;
      bus.ID        = 6'b00_0111;
      bvalid        = 5'b00001;
      bresp[0]      = 2'b10;
      mready        = '0;
      @(negedge clk);
      check("rst_hold_accept", bready, 1);
      @(posedge clk); #1;
      bus.ID_valid = 1'b0;
      bvalid       = '0;
      @(negedge clk);
      check("rst_hold_m0_valid", bus.M0_BVALID, 1);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset  = 1'b0;
      mready = 3'b111;
      @(negedge clk);
      check_outputs_zero("mid_hold_reset");
      repeat (3) begin
         @(negedge clk);
         check("post_reset_no_retire", bus.count_update, 0);
         check("post_reset_no_valid", mvalid, 0);
      end

      check("scoreboard_empty", sbq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
